// File: rtl/servo_pkg.sv
// Shared definitions for the servo path: FSM state encoding, default
// position range, and the helper that sizes interval timers.
// Pure declarations, no logic.
package servo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int DEF_POS_W     = 8;
    localparam int DEF_POS_MAX   = 180;
    localparam int DEF_POS_RESET = 90;

    // Width of a down-counter that must hold reload values up to max(a,b)-1.
    // Never narrower than one bit so a degenerate interval still elaborates.
    function automatic int timer_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m <= 2) begin
            return 1;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Loadable down-counter with a zero flag, shared by step and settle timing.
// A load takes effect on the next edge; otherwise counts down to 0 and holds.
// No handshake: the owner decides when to load and when to act on zero.
module tick_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load has priority; otherwise decrement until the counter parks at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/servo_motion_sequencer.sv
// Rate-limited position sequencer: walks cur_pos one degree per STEP_DIV
// cycles toward an accepted target, then holds one servo frame and pulses done.
// tgt_ready is high only in IDLE; requests arriving while busy wait there.
module servo_motion_sequencer
    import servo_pkg::*;
#(
    parameter int CLK_HZ    = 16000000,
    parameter int SERVO_HZ  = 50,
    parameter int STEP_HZ   = 500,
    parameter int POS_W     = DEF_POS_W,
    parameter int POS_MAX   = DEF_POS_MAX,
    parameter int POS_RESET = DEF_POS_RESET
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] tgt_pos,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] cur_pos,
    output logic             busy,
    output logic             done
);

    localparam int SETTLE_CYCLES = CLK_HZ / SERVO_HZ;
    localparam int STEP_DIV      = CLK_HZ / STEP_HZ;
    localparam int TW            = timer_w(STEP_DIV, SETTLE_CYCLES);

    localparam logic [TW-1:0]    STEP_RELOAD   = TW'(STEP_DIV - 1);
    localparam logic [TW-1:0]    SETTLE_RELOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    TIMER_ONE     = TW'(1);
    localparam logic [POS_W-1:0] POS_MAX_V     = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_RESET_V   = POS_W'(POS_RESET);

    state_t             state;
    logic [POS_W-1:0]   target;
    logic [POS_W-1:0]   tgt_clamped;
    logic               accept;
    logic               moving_needed;
    logic               timer_load;
    logic [TW-1:0]      timer_load_val;
    logic [TW-1:0]      timer_count;
    logic               timer_zero;
    logic               timer_last;

    assign tgt_ready     = (state == ST_IDLE);
    assign accept        = tgt_valid && tgt_ready;
    assign tgt_clamped   = (tgt_pos > POS_MAX_V) ? POS_MAX_V : tgt_pos;
    assign moving_needed = (tgt_clamped != cur_pos);

    // The registered step/done pulses are launched when the timer is at 1 so
    // that they are visible in the same cycle the timer reads 0; the state
    // decisions (reload, leave MOVE/SETTLE) are taken while it reads 0.
    assign timer_last = (timer_count == TIMER_ONE);

    // Timer reload: step interval on accept and after each step, settle
    // interval once the last step has landed on the target.
    always_comb begin
        timer_load     = 1'b0;
        timer_load_val = STEP_RELOAD;
        case (state)
            ST_IDLE: begin
                if (accept && moving_needed) begin
                    timer_load = 1'b1;
                end
            end
            ST_MOVE: begin
                if (timer_zero) begin
                    timer_load     = 1'b1;
                    timer_load_val = (cur_pos == target) ? SETTLE_RELOAD : STEP_RELOAD;
                end
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    tick_divider #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .load_val(timer_load_val),
        .count   (timer_count),
        .zero    (timer_zero)
    );

    // Sequencer FSM with registered outputs; step and done default to 0 so
    // they are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_pos <= POS_RESET_V;
            target  <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        target <= tgt_clamped;
                        if (!moving_needed) begin
                            done <= 1'b1;
                        end else begin
                            dir   <= (tgt_clamped > cur_pos);
                            busy  <= 1'b1;
                            state <= ST_MOVE;
                        end
                    end
                end
                ST_MOVE: begin
                    // cur_pos only moves toward target, which is already
                    // clamped, so it cannot leave 0..POS_MAX or wrap.
                    if (timer_last) begin
                        step    <= 1'b1;
                        cur_pos <= dir ? (cur_pos + POS_W'(1)) : (cur_pos - POS_W'(1));
                    end
                    if (timer_zero && (cur_pos == target)) begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_last) begin
                        done <= 1'b1;
                    end
                    if (timer_zero) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Scoreboard bench for servo_motion_sequencer with STEP_DIV=4, SETTLE_CYCLES=8.
// Cycle T is the cycle whose ending edge samples the accept; outputs are
// sampled on the falling edge and cycle numbers come from a free-running count.
module tb_servo_motion_sequencer;

    localparam int STEP_DIV = 4;
    localparam int SETTLE   = 8;
    localparam int PMAX     = 180;

    logic       clk;
    logic       rst;
    logic [7:0] tgt_pos;
    logic       tgt_valid;
    logic       tgt_ready;
    logic       step;
    logic       dir;
    logic [7:0] cur_pos;
    logic       busy;
    logic       done;

    servo_motion_sequencer #(
        .CLK_HZ   (1000),
        .SERVO_HZ (125),
        .STEP_HZ  (250),
        .POS_W    (8),
        .POS_MAX  (180),
        .POS_RESET(90)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tgt_pos  (tgt_pos),
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .step     (step),
        .dir      (dir),
        .cur_pos  (cur_pos),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        int pos;
        int dir;
    } step_ev_t;

    step_ev_t step_q[$];
    int       done_q[$];
    int       win_lo    = 1;
    int       win_hi    = 0;
    bit       mon_en    = 1'b0;
    int       model_pos = 90;
    step_ev_t ev;
    int       dexp;
    bit       inw;

    // Reference model: an accept sampled at the end of cycle t produces
    // steps at t+n*STEP_DIV, done at t+k*STEP_DIV+SETTLE, busy over t+1..done.
    function automatic void expect_cmd(input int t, input int tgt);
        int c;
        int k;
        int d;
        step_ev_t e;
        c = (tgt > PMAX) ? PMAX : tgt;
        d = (c > model_pos) ? 1 : 0;
        k = d ? (c - model_pos) : (model_pos - c);
        for (int n = 1; n <= k; n++) begin
            e.cyc = t + n * STEP_DIV;
            e.pos = d ? (model_pos + n) : (model_pos - n);
            e.dir = d;
            step_q.push_back(e);
        end
        if (k == 0) begin
            done_q.push_back(t + 1);
            win_lo = 1;
            win_hi = 0;
        end else begin
            done_q.push_back(t + k * STEP_DIV + SETTLE);
            win_lo = t + 1;
            win_hi = t + k * STEP_DIV + SETTLE;
        end
        model_pos = c;
    endfunction

    // Output monitor: pop the scoreboard on every step/done pulse and check
    // busy/ready against the expected busy window every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (step) begin
                if (step_q.size() == 0) begin
                    check("step_extra", 1, 0);
                end else begin
                    ev = step_q.pop_front();
                    check("step_cyc", cyc, ev.cyc);
                    check("step_pos", int'(cur_pos), ev.pos);
                    check("step_dir", int'(dir), ev.dir);
                end
            end else if (step_q.size() > 0 && cyc > step_q[0].cyc) begin
                check("step_missing", cyc, step_q[0].cyc);
                void'(step_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_extra", 1, 0);
                end else begin
                    dexp = done_q.pop_front();
                    check("done_cyc", cyc, dexp);
                end
            end else if (done_q.size() > 0 && cyc > done_q[0]) begin
                check("done_missing", cyc, done_q[0]);
                void'(done_q.pop_front());
            end
            inw = (cyc >= win_lo) && (cyc <= win_hi);
            check("busy", int'(busy), int'(inw));
            check("ready", int'(tgt_ready), int'(!inw));
        end
    end

    task automatic send(input int tgt);
        int guard;
        guard = 0;
        @(negedge clk);
        #2;
        tgt_pos   = 8'(tgt);
        tgt_valid = 1'b1;
        while (!tgt_ready && guard < 2000) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (guard >= 2000) begin
            check("accept_timeout", 0, 1);
        end
        expect_cmd(cyc, tgt);
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((cyc <= win_hi || step_q.size() > 0 || done_q.size() > 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            check("idle_timeout", 0, 1);
        end
        @(negedge clk);
        check("pos_final", int'(cur_pos), model_pos);
    endtask

    initial begin
        int t0;
        rst       = 1'b0;
        tgt_valid = 1'b0;
        tgt_pos   = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pos", int'(cur_pos), 90);
        check("rst_ready", int'(tgt_ready), 1);
        check("rst_step", int'(step), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        #2 rst = 1'b0;
        mon_en = 1'b1;

        // Abort mid-motion toward 93 while a second request is held pending.
        send(93);
        t0 = win_lo - 1;
        tgt_pos   = 8'd0;
        tgt_valid = 1'b1;
        while (cyc < t0 + 6) @(negedge clk);
        #2;
        rst    = 1'b1;
        mon_en = 1'b0;
        #1;
        check("abort_pos", int'(cur_pos), 90);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_step", int'(step), 0);
        check("abort_ready", int'(tgt_ready), 1);
        step_q.delete();
        done_q.delete();
        win_lo    = 1;
        win_hi    = 0;
        model_pos = 90;
        @(negedge clk);
        #2;
        rst = 1'b0;
        expect_cmd(cyc, 0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        wait_idle();

        send(90);  wait_idle();
        send(93);  wait_idle();
        send(90);  wait_idle();
        send(88);
        send(90);  wait_idle();
        send(90);  wait_idle();
        send(179); wait_idle();
        send(200); wait_idle();

        check("stepq_left", step_q.size(), 0);
        check("doneq_left", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/servo_motion_sequencer.md
# servo_motion_sequencer

Rate-limited position sequencer for the servo path: accepts an absolute target angle over a valid/ready handshake and emits one-cycle `step` pulses with a stable `dir` level, walking the tracked position one degree at a time until it reaches the target. It then holds for one servo frame so the pulse-width output can settle, and reports completion. It sits between command logic (host or pattern generator) and `servo_driver`, and drives that block's `step`/`dir` inputs.

## Interface
- `CLK_HZ`, default 16000000: system clock frequency.
- `SERVO_HZ`, default 50: servo frame rate.
  - Settle time is `SETTLE_CYCLES = CLK_HZ/SERVO_HZ` (localparam).
- `STEP_HZ`, default 500: maximum step rate.
  - Step period is `STEP_DIV = CLK_HZ/STEP_HZ` (localparam, must be ≥2).
- `POS_W`, default 8: position width.
- `POS_MAX`, default 180: highest legal position in degrees.
- `POS_RESET`, default 90: position assumed after reset.
- `clk` in 1: the only clock. All logic is on the rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `tgt_pos` in POS_W: requested absolute position.
- `tgt_valid` in 1: the requester has a target.
- `tgt_ready` out 1: the block accepts a target this cycle. High only in IDLE.
- `step` out 1: one-cycle pulse, one degree of motion.
- `dir` out 1: 1 = increment, 0 = decrement. Stable while moving.
- `cur_pos` out POS_W: tracked position.
- `busy` out 1: high in MOVE and SETTLE.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- The FSM has three states: IDLE, MOVE, SETTLE. All outputs are registered except `tgt_ready`, which is decoded from the state.
- Reset values:
  - state = IDLE
  - `cur_pos` = POS_RESET
  - `step` = 0, `dir` = 0, `done` = 0, `busy` = 0
  - `tgt_ready` = 1
  - target register and timer = 0
- IDLE, on accept (`tgt_valid && tgt_ready`):
  - Latch the target, clamped as `min(tgt_pos, POS_MAX)`.
  - If the clamped target equals `cur_pos`: pulse `done` and stay in IDLE.
  - Otherwise: set `dir = (target > cur_pos)`, load the timer with STEP_DIV-1, and go to MOVE.
- MOVE:
  - The timer decrements each cycle.
  - When the timer is 0: pulse `step`, change `cur_pos` by ±1 per `dir`, and reload the timer with STEP_DIV-1.
  - If the updated `cur_pos` equals the target: load the timer with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - The timer decrements each cycle. When it reaches 0: pulse `done` and go to IDLE.
- `dir` changes only on accept and never in the same cycle as `step`.
- `cur_pos` never leaves 0..POS_MAX and never wraps.
- `tgt_valid` in MOVE or SETTLE is ignored. The requester holds it until `tgt_ready` rises.
- Asserting `rst` mid-motion aborts immediately to the reset values. No `done` is produced for the aborted command.

## Timing
- An accept sampled at edge T (T = the clock edge at which `tgt_valid && tgt_ready` is sampled) moves k = |target − `cur_pos`| degrees:
  - The n-th `step` is high during cycle T+n·STEP_DIV, for n = 1..k.
  - `cur_pos` shows the new value from the same cycle as its `step` pulse.
  - `done` is high during cycle T+k·STEP_DIV+SETTLE_CYCLES.
  - `busy` goes high at T+1 and falls together with `done`.
  - `tgt_ready` returns in the cycle after `done`.
- Zero-distance command: `done` is high in cycle T+1. `busy` and `step` stay 0, and `tgt_ready` stays 1.
- Back-to-back throughput: a new target can be accepted 1 cycle after `done`.
- Timer width is `$clog2(max(STEP_DIV, SETTLE_CYCLES))`. Position comparisons are unsigned, POS_W bits wide.

## Structure
- Shared package `servo_pkg` holds:
  - the state enum (IDLE/MOVE/SETTLE)
  - the default POS_W, POS_MAX and POS_RESET
  - the `clog2`-based timer-width helper
- One natural sub-module: `tick_divider`, a loadable down-counter with a zero flag.
  - It serves both the step interval and the settle interval.
  - It will be reused by later servo blocks.

## Test plan
Bench parameters: CLK_HZ=1000, STEP_HZ=250 (STEP_DIV=4), SERVO_HZ=125 (SETTLE_CYCLES=8).
- Reset → `cur_pos`=90, `tgt_ready`=1, and `step`/`dir`/`busy`/`done` all 0.
- Accept 93 at T:
  - `dir`=1 from T+1
  - `step` at T+4, T+8, T+12
  - `cur_pos` goes 91, 92, 93
  - `done` at T+20
  - `busy` high T+1..T+20
- Accept 88 at T (from 90):
  - `dir`=0
  - `step` at T+4 and T+8
  - `done` at T+16
  - `cur_pos`=88
- Accept 90 while at 90 → `done` at T+1, no `step`, `busy` never rises.
- Accept 200 from 179 → clamped to 180:
  - exactly one `step`
  - `cur_pos`=180
  - `done` at T+12
- Hold `tgt_valid` with 0 during MOVE toward 93, then pulse `rst` at T+6:
  - The target is not accepted while busy.
  - After `rst`: `cur_pos`=90, state IDLE, no `done`.
  - The held request is accepted on the first cycle after reset deasserts.
